// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state type and frame sizes for the TM1638 display driver.
package tm1638_pkg;

  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON    = 8'h88;

  localparam logic [4:0] F1_BYTES = 5'd1;
  localparam logic [4:0] F2_BYTES = 5'd17;
  localparam logic [4:0] F3_BYTES = 5'd1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    BIT_LO,
    BIT_HI,
    HOLD,
    GAP
  } state_t;

  function automatic logic [4:0] frame_bytes(input logic [1:0] frame);
    case (frame)
      2'd0:    return F1_BYTES;
      2'd1:    return F2_BYTES;
      default: return F3_BYTES;
    endcase
  endfunction

endpackage

// File: rtl/tm1638_driver_hex_to_7seg.sv
// Hex nibble to TM1638 segment byte (bit0=a .. bit6=g, dp off).
module hex_to_7seg (
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'h00;
    case (hex)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
      default: seg = 8'h00;
    endcase
  end

endmodule

// File: rtl/tm1638_driver.sv
// TM1638 write-only serial driver: shows a latched 32-bit word as eight hex digits.
// Handshake: start is taken only in IDLE; busy covers the whole transfer; done pulses as busy drops.
module tm1638_driver
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [2:0]  brightness,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio,
  output state_t      dbg_state
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [4:0]    byte_cnt;
  logic [1:0]    frame;
  logic [31:0]   data_q;
  logic [2:0]    bri_q;

  logic [4:0] sel_byte;
  logic [2:0] sel_bit;
  logic [2:0] digit;
  logic [3:0] nibble;
  logic [7:0] seg;
  logic [7:0] tx_byte;
  logic       half_end;
  logic       gap_end;
  logic       last_byte;

  assign dbg_state = state;
  assign half_end  = (cnt == HALF_END);
  assign gap_end   = (cnt == GAP_END);
  assign last_byte = (byte_cnt == frame_bytes(frame) - 5'd1);

  // DIO is loaded on entry to BIT_LO, so look up the bit that is about to go out.
  always_comb begin
    sel_byte = byte_cnt;
    sel_bit  = bit_cnt;
    if (state == BIT_HI) begin
      sel_bit = bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) sel_byte = byte_cnt + 5'd1;
    end
  end

  // F2 byte n>0 is address n-1; odd bytes hold the digit segments, even ones the LEDs.
  assign digit  = 3'((sel_byte - 5'd1) >> 1);
  assign nibble = data_q[{~digit, 2'b00} +: 4];

  hex_to_7seg u_seg (
    .hex (nibble),
    .seg (seg)
  );

  always_comb begin
    tx_byte = 8'h00;
    case (frame)
      2'd0: tx_byte = CMD_WRITE_AUTO;
      2'd1: begin
        if (sel_byte == 5'd0) tx_byte = CMD_ADDR0;
        else if (sel_byte[0]) tx_byte = seg;
      end
      default: tx_byte = CMD_DISP_ON | {5'd0, bri_q};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      frame    <= '0;
      data_q   <= '0;
      bri_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tm_stb   <= 1'b1;
      tm_clk   <= 1'b1;
      tm_dio   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_q   <= data;
            bri_q    <= brightness;
            busy     <= 1'b1;
            tm_stb   <= 1'b0;
            cnt      <= '0;
            frame    <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (half_end) begin
            cnt    <= '0;
            tm_clk <= 1'b0;
            tm_dio <= tx_byte[sel_bit];
            state  <= BIT_LO;
          end else cnt <= cnt + CNT_ONE;
        end
        BIT_LO: begin
          if (half_end) begin
            cnt    <= '0;
            tm_clk <= 1'b1;
            state  <= BIT_HI;
          end else cnt <= cnt + CNT_ONE;
        end
        BIT_HI: begin
          if (half_end) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && last_byte) begin
              state <= HOLD;
            end else begin
              if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 5'd1;
              tm_clk <= 1'b0;
              tm_dio <= tx_byte[sel_bit];
              state  <= BIT_LO;
            end
          end else cnt <= cnt + CNT_ONE;
        end
        HOLD: begin
          if (half_end) begin
            cnt    <= '0;
            tm_stb <= 1'b1;
            tm_dio <= 1'b1;
            if (frame == 2'd2) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end else cnt <= cnt + CNT_ONE;
        end
        GAP: begin
          if (gap_end) begin
            cnt      <= '0;
            tm_stb   <= 1'b0;
            frame    <= frame + 2'd1;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SETUP;
          end else cnt <= cnt + CNT_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_driver.sv
// Bench for tm1638_driver: decodes the STB/CLK/DIO pins into bytes and frames and scores them.
module tb_tm1638_driver;
  import tm1638_pkg::*;

  localparam int CLK_DIV     = 2;
  localparam int BUSY_CYCLES = 314 * CLK_DIV;
  localparam int WAIT_LIMIT  = BUSY_CYCLES + 40;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bri;
    logic [7:0]  f3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic [2:0]  brightness = '0;
  logic        start = 1'b0;
  logic        busy, done, tm_stb, tm_clk, tm_dio;
  state_t      dbg_state;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int         exp_len_q[$];
  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  tm1638_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .brightness (brightness),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .tm_stb     (tm_stb),
    .tm_clk     (tm_clk),
    .tm_dio     (tm_dio),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard feeders ----------------
  task automatic push_transfer(input vec_t v);
    exp_q.push_back(8'h40);
    exp_len_q.push_back(1);
    exp_q.push_back(8'hC0);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(seg_tab[v.data[31-4*k -: 4]]);
      exp_q.push_back(8'h00);
    end
    exp_len_q.push_back(17);
    exp_q.push_back(v.f3);
    exp_len_q.push_back(1);
  endtask

  // ---------------- pin monitor / decoder ----------------
  logic       p_stb = 1'b1, p_clk = 1'b1, p_dio = 1'b1, p_busy = 1'b0;
  logic       rise_busy = 1'b0, chk_gap = 1'b0;
  logic [7:0] sh = '0;
  int         bits = 0, nbytes = 0, same = 0, stb_hi = 0;
  int         busy_len = 0, low_run = 0, windows = 0, dones = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_stb = 1'b1; p_clk = 1'b1; p_dio = 1'b1; p_busy = 1'b0; rise_busy = 1'b0;
      bits = 0; nbytes = 0; same = 0; stb_hi = 0; busy_len = 0; low_run = 0;
    end else begin
      same = (tm_dio == p_dio) ? same + 1 : 1;
      if (tm_stb != p_stb) check("stb_toggle_clk_high", {31'd0, tm_clk}, 32'd1);
      if (!tm_stb && p_stb && rise_busy)
        check("stb_gap_len", {31'd0, stb_hi >= 2 * CLK_DIV}, 32'd1);
      if (tm_stb && !p_stb) begin
        rise_busy = busy;
        if (exp_len_q.size() == 0) check("frame_unexpected", 32'd1, 32'd0);
        else check("frame_len", nbytes, exp_len_q.pop_front());
        check("frame_partial_bits", bits, 32'd0);
        nbytes = 0;
        bits   = 0;
        stb_hi = 0;
      end
      if (tm_stb) stb_hi++;
      if (tm_stb && busy) check("dio_high_in_gap", {31'd0, tm_dio}, 32'd1);
      if (!tm_stb && tm_clk && !p_clk) begin
        check("dio_setup", {31'd0, same > CLK_DIV}, 32'd1);
        sh = {tm_dio, sh[7:1]};
        bits++;
        if (bits == 8) begin
          bits = 0;
          nbytes++;
          if (exp_q.size() == 0) check("byte_unexpected", 32'd1, 32'd0);
          else check("byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
        end
      end
      if (busy && !p_busy) begin
        if (chk_gap) check("idle_between", low_run, 32'd1);
        busy_len = 0;
      end
      if (done || (!busy && p_busy))
        check("done_pulse", {31'd0, done}, {31'd0, !busy && p_busy});
      if (done) dones++;
      if (!busy && p_busy) begin
        check("busy_len", busy_len, BUSY_CYCLES);
        windows++;
        low_run = 0;
      end
      if (busy) busy_len++;
      else low_run++;
      p_stb = tm_stb; p_clk = tm_clk; p_dio = tm_dio; p_busy = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_start(input vec_t v);
    @(negedge clk);
    data = v.data;
    brightness = v.bri;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_transfer(input vec_t v);
    push_transfer(v);
    pulse_start(v);
    wait_done(WAIT_LIMIT);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("idle_pins", {29'd0, tm_stb, tm_clk, tm_dio}, 32'd7);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [4];
  vec_t v;
  int   win0, done0, n;

  initial begin
    vecs[0] = '{data: 32'h1234_5678, bri: 3'd7, f3: 8'h8F};
    vecs[1] = '{data: 32'hFFFF_FFFF, bri: 3'd0, f3: 8'h88};
    vecs[2] = '{data: 32'h89AB_CDEF, bri: 3'd5, f3: 8'h8D};
    vecs[3] = '{data: 32'h0000_0000, bri: 3'd3, f3: 8'h8B};

    repeat (3) @(negedge clk);
    check("rst_pins", {29'd0, tm_stb, tm_clk, tm_dio}, 32'd7);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_transfer(vecs[i]);
    check("windows_table", windows, 32'd4);
    check("dones_table", dones, 32'd4);

    // start held high: three back-to-back transfers
    v = '{data: 32'hA5A5_0F0F, bri: 3'd2, f3: 8'h8A};
    win0 = windows;
    done0 = dones;
    for (int i = 0; i < 3; i++) push_transfer(v);
    @(negedge clk);
    data = v.data;
    brightness = v.bri;
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk_gap = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done(WAIT_LIMIT);
      if (i == 2) start = 1'b0;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk_gap = 1'b0;
    check("held_windows", windows - win0, 32'd3);
    check("held_dones", dones - done0, 32'd3);
    check("held_queue_drained", exp_q.size(), 32'd0);
    check("held_not_busy", {31'd0, busy}, 32'd0);

    // data changes mid-F2: the latched word must still be shown
    v = '{data: 32'h1234_5678, bri: 3'd3, f3: 8'h8B};
    push_transfer(v);
    pulse_start(v);
    repeat (100) @(negedge clk);
    data = 32'h0;
    wait_done(WAIT_LIMIT);
    @(negedge clk);
    check("toggle_queue_drained", exp_q.size(), 32'd0);
    run_transfer('{data: 32'h0000_0000, bri: 3'd3, f3: 8'h8B});

    // reset at cycle 100 of a transfer
    v = '{data: 32'h1234_5678, bri: 3'd7, f3: 8'h8F};
    push_transfer(v);
    pulse_start(v);
    n = 0;
    while (busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("busy_timeout", 32'd1, 32'd0);
    repeat (99) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_len_q.delete();
    #1;
    check("midrst_pins", {29'd0, tm_stb, tm_clk, tm_dio}, 32'd7);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_transfer('{data: 32'hDEAD_BEEF, bri: 3'd1, f3: 8'h89});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
